instr_intake: RTL
=================

// Module: instr_intake
// PURPOSE
//  CPU-side receiver for the instruction-issue interface (instrword + newinstr pulse) feeding mipscpu.
//  Detects each newinstr rising edge and captures instrword into a small in-order queue.
//  Presents queued words to the control FSM over a valid/ready handshake.
//  Reports occupancy, overflow and a retired-instruction count.
// PARAMETERS
//  INSTR_W  32  instruction word width
//  DEPTH    4   queue entries; power of two, >= 2
//  CNT_W    16  width of retired-instruction counter
// PORTS
//  clock        in   1        single clock, rising edge
//  reset        in   1        asynchronous, active-low; clears all state
//  newinstr     in   1        issue strobe; issuer holds it high >= 1 clock cycle per instruction
//  instrword    in   INSTR_W  instruction; stable while newinstr is high
//  instr_out    out  INSTR_W  head-of-queue word
//  instr_valid  out  1        instr_out holds a valid instruction
//  instr_ready  in   1        control FSM accepts head this cycle
//  opcode       out  6        instr_out[31:26]
//  illegal      out  1        head opcode/funct not in {R-add, R-sub, lw, sw}; qualified by instr_valid
//  count        out  $clog2(DEPTH)+1  current occupancy
//  full         out  1        count == DEPTH
//  empty        out  1        count == 0
//  overflow     out  1        sticky: an issue was dropped because the queue was full
//  retired      out  CNT_W    number of pops since reset; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (reset==0, async): newinstr_q=0, rd/wr ptrs=0, count=0, overflow=0, retired=0.
//   After reset: instr_out=0, instr_valid=0, empty=1, full=0, illegal=0.
//  Edge detect: newinstr_q <= newinstr every cycle. rise = newinstr & ~newinstr_q.
//   A strobe held N cycles yields exactly one push.
//  Push: on a clock edge where rise=1 and the queue is not full (after a same-cycle pop), write instrword at wr_ptr.
//   Then increment wr_ptr (wraps at DEPTH).
//  Pop: on a clock edge where instr_valid & instr_ready, increment rd_ptr (wraps) and increment retired.
//  Latency: instrword sampled at edge E (rise=1) is visible on instr_out with instr_valid=1 immediately after E,
//   when the queue was empty. No combinational bypass from instrword to instr_out.
//  instr_valid = ~empty. instr_out = mem[rd_ptr], registered storage, combinational read.
//  Handshake: instr_out is stable while instr_valid=1 and instr_ready=0. instr_ready while instr_valid=0 is ignored.
//  Simultaneous push+pop:
//   - Not empty: count is unchanged and both pointers advance.
//   - Full: the pop frees a slot and the push is accepted.
//   - Empty: there is no pop, and the push proceeds normally.
//  Push while full (no same-cycle pop): the word is dropped, all pointers hold, and overflow <= 1 until reset.
//  illegal: combinational decode of the head:
//   - legal = (op==OP_RTYPE && fun in {FUN_ADD, FUN_SUB}) || op==OP_LW || op==OP_SW.
//   - illegal = instr_valid & ~legal.
//   - Illegal words are still queued and popped normally.
//  Reset asserted mid-operation: queue contents are discarded. A newinstr held high across reset release
//   is counted as a fresh rise (newinstr_q cleared).
//  count is a registered counter, not derived from pointer difference; full/empty decoded from count.
// STRUCTURE
//  Package mips_pkg: INSTR_W, OP_RTYPE=6'd0, OP_LW=6'd35, OP_SW=6'd43, FUN_ADD=6'd32, FUN_SUB=6'd34,
//   plus field-slice localparams (OP_MSB/LSB, FUN_MSB/LSB).
//  One sub-module: sync_fifo (DATA_W, DEPTH), holding ptrs, count, full/empty and the storage array.
//  Top level holds the edge detector, overflow flag, retired counter and the illegal decode.
// TESTING
//  1. Reset then idle 5 cycles -> instr_valid=0, empty=1, count=0, overflow=0, retired=0.
//  2. Issue lw $1,0($0) (0x8C010000) with newinstr held 3 cycles, ready=0
//     -> count=1, instr_out=0x8C010000, opcode=35, illegal=0.
//     Then ready=1 for 1 cycle -> empty, retired=1.
//  3. ready=0; issue 5 words 0x8C010000, 0x8C020001, 0x8C030002, 0x00222020 (add), 0x00832822 (sub)
//     -> first 4 queued, full=1, overflow=1.
//     Drain order 0x8C010000..0x00222020; sub is absent.
//  4. Queue full (4 entries); assert ready and issue 0xAC050003 (sw) in the same cycle
//     -> count stays 4, overflow unchanged, sw appears as the 4th entry after 3 more pops.
//  5. Issue 0x08000000 (opcode 2) -> queued, instr_valid=1, illegal=1; pop -> illegal=0, retired increments.
//  6. Push 2 words, pull reset low between clock edges -> outputs clear immediately: empty=1, count=0, retired=0.
//     With newinstr held high through release, exactly one push follows.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared constants for the MIPS instruction-intake path:
//                default word width, the opcode/funct values the intake
//                treats as legal, and the bit positions of those fields.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int INSTR_W  = 32;

    // Field positions inside a 32-bit MIPS instruction word
    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 26;
    localparam int FUN_MSB  = 5;
    localparam int FUN_LSB  = 0;

    // Opcodes and R-type function codes accepted as legal
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] FUN_ADD  = 6'd32;
    localparam logic [5:0] FUN_SUB  = 6'd34;

    // True for the supported subset: R-type add/sub, lw, sw
    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fun);
        return ((op == OP_RTYPE) && ((fun == FUN_ADD) || (fun == FUN_SUB)))
               || (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock in-order queue with registered storage and a
//                combinational head read. Occupancy is a dedicated counter;
//                full/empty are decoded from it.
//  Ports       : clock    - rising-edge clock
//                reset    - asynchronous active-low reset
//                i_push   - write request (dropped when full and no pop)
//                i_pop    - read request (ignored when empty)
//                i_data   - write data
//                o_data   - head-of-queue word
//                o_count  - current occupancy
//                o_full   - count == DEPTH
//                o_empty  - count == 0
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [DATA_W-1:0]          i_data,
    output logic [DATA_W-1:0]          o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic              w_pop;
    logic              w_push;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

    // A pop in the same cycle frees a slot, so a push into a full queue
    // is still accepted when it coincides with a pop.
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Pointers are AW bits wide and DEPTH is a power of two, so they wrap
    // naturally. Storage is cleared on reset so the head reads zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/instr_intake.sv
`default_nettype none
// ============================================================================
//  Module      : instr_intake
//  Description : CPU-side receiver for the instruction-issue interface.
//                Captures instrword once per newinstr rising edge into an
//                in-order queue and presents the head over valid/ready.
//                Reports occupancy, a sticky overflow flag, a retired count
//                and whether the head is outside the supported subset.
//  Ports       : clock, reset(async, active-low)
//                newinstr, instrword          - issue strobe and word
//                instr_out, instr_valid       - head word / valid
//                instr_ready                  - consumer accepts head
//                opcode, illegal              - head decode
//                count, full, empty           - occupancy
//                overflow                     - sticky dropped-issue flag
//                retired                      - pops since reset (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_intake #(
    parameter int INSTR_W = mips_pkg::INSTR_W,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     newinstr,
    input  logic [INSTR_W-1:0]       instrword,
    output logic [INSTR_W-1:0]       instr_out,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [5:0]               opcode,
    output logic                     illegal,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [CNT_W-1:0]         retired
);

    import mips_pkg::*;

    logic             r_newinstr_q;
    logic             r_overflow;
    logic [CNT_W-1:0] r_retired;

    logic             w_rise;
    logic             w_pop;
    logic             w_drop;

    // One push per strobe regardless of how long the issuer holds it.
    // r_newinstr_q resets low, so a strobe held across reset release
    // counts as a fresh rise.
    assign w_rise = newinstr & ~r_newinstr_q;
    assign w_pop  = instr_valid & instr_ready;
    assign w_drop = w_rise & full & ~w_pop;

    sync_fifo #(
        .DATA_W (INSTR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_rise),
        .i_pop   (w_pop),
        .i_data  (instrword),
        .o_data  (instr_out),
        .o_count (count),
        .o_full  (full),
        .o_empty (empty)
    );

    assign instr_valid = ~empty;
    assign opcode      = instr_out[OP_MSB:OP_LSB];
    assign illegal     = instr_valid & ~is_legal(instr_out[OP_MSB:OP_LSB],
                                                 instr_out[FUN_MSB:FUN_LSB]);
    assign overflow    = r_overflow;
    assign retired     = r_retired;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_newinstr_q <= 1'b0;
            r_overflow   <= 1'b0;
            r_retired    <= '0;
        end else begin
            r_newinstr_q <= newinstr;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_pop) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

endmodule : instr_intake
`default_nettype wire
